// File: rtl/tlb_cache_pkg.sv
// tlb_cache_pkg: shared TLB types and default geometry
package tlb_cache_pkg;
  localparam int bit_count = 32;
  localparam int ram_address_width = 32;
  localparam int page_size = 4096;
  localparam int tlb_entries = 8;
  localparam int tlb_ofs = $clog2(page_size);
  typedef enum logic {IDLE, WALK} tlb_state_t;
  typedef struct packed {
    logic valid;
    logic [bit_count-tlb_ofs-1:0] vpn;
    logic [ram_address_width-tlb_ofs-1:0] ppn;
  } tlb_entry_t;
endpackage

// File: rtl/tlb_cache_if.sv
// tlb_cache_if: request/response, walker refill and invalidate signals of the TLB
interface tlb_cache_if
  import tlb_cache_pkg::*;
#(
  parameter int VADDR_WIDTH = bit_count,
  parameter int PADDR_WIDTH = ram_address_width,
  parameter int PAGE_SIZE = page_size
);
  localparam int OFS = $clog2(PAGE_SIZE);
  localparam int VPN_W = VADDR_WIDTH - OFS;
  localparam int PPN_W = PADDR_WIDTH - OFS;
  logic req_valid;
  logic req_ready;
  logic [VADDR_WIDTH-1:0] req_vaddr;
  logic resp_valid;
  logic [PADDR_WIDTH-1:0] resp_paddr;
  logic resp_fault;
  logic walk_req;
  logic [VPN_W-1:0] walk_vpn;
  logic walk_ack;
  logic [PPN_W-1:0] walk_ppn;
  logic walk_fault;
  logic flush;
  logic inval_valid;
  logic [VPN_W-1:0] inval_vpn;
  modport slave (
    input req_valid, req_vaddr, walk_ack, walk_ppn, walk_fault, flush, inval_valid, inval_vpn,
    output req_ready, resp_valid, resp_paddr, resp_fault, walk_req, walk_vpn
  );
  modport master (
    output req_valid, req_vaddr, walk_ack, walk_ppn, walk_fault, flush, inval_valid, inval_vpn,
    input req_ready, resp_valid, resp_paddr, resp_fault, walk_req, walk_vpn
  );
endinterface

// File: rtl/tlb_cache_victim_sel.sv
// tlb_victim_sel: picks the lowest invalid slot, else the round-robin pointer
module tlb_victim_sel #(
  parameter int ENTRIES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [ENTRIES-1:0] valid,
  input  logic adv,
  output logic [$clog2(ENTRIES)-1:0] victim,
  output logic full
);
  localparam int IW = $clog2(ENTRIES);
  logic [IW-1:0] ptr_q, ptr_d;
  assign full = &valid;
  always_comb begin
    victim = ptr_q;
    for (int i = ENTRIES - 1; i >= 0; i--) if (!valid[i]) victim = IW'(i);
    ptr_d = (adv && full) ? ptr_q + IW'(1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/tlb_cache.sv
// tlb_cache: fully associative TLB with walker refill; define TLB_PERF_EN for hit/miss counters
module tlb_cache
  import tlb_cache_pkg::*;
#(
  parameter int ENTRIES = tlb_entries,
  parameter int VADDR_WIDTH = bit_count,
  parameter int PADDR_WIDTH = ram_address_width,
  parameter int PAGE_SIZE = page_size
) (
  input logic clk,
  input logic rst,
  tlb_cache_if.slave bus
`ifdef TLB_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int OFS = $clog2(PAGE_SIZE);
  localparam int VPN_W = VADDR_WIDTH - OFS;
  localparam int PPN_W = PADDR_WIDTH - OFS;
  tlb_state_t state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d, match;
  logic [VPN_W-1:0] tag_q [ENTRIES], tag_d [ENTRIES];
  logic [PPN_W-1:0] ppn_q [ENTRIES], ppn_d [ENTRIES];
  logic [VPN_W-1:0] walk_vpn_q, walk_vpn_d, req_vpn;
  logic [OFS-1:0] ofs_q, ofs_d;
  logic [PADDR_WIDTH-1:0] resp_paddr_q, resp_paddr_d;
  logic resp_valid_q, resp_valid_d, resp_fault_q, resp_fault_d, kill_q, kill_d;
  logic [PPN_W-1:0] hit_ppn;
  logic accept, hit, ack, inval_walk, install, full;
  logic [$clog2(ENTRIES)-1:0] victim;

  tlb_victim_sel #(.ENTRIES(ENTRIES)) u_victim (
    .clk(clk), .rst(rst), .valid(valid_q), .adv(install), .victim(victim), .full(full)
  );

  assign req_vpn = bus.req_vaddr[VADDR_WIDTH-1:OFS];
  assign bus.req_ready = rst && state_q == IDLE && !bus.flush && !bus.inval_valid;
  assign bus.walk_req = state_q == WALK;
  assign bus.walk_vpn = walk_vpn_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_paddr = resp_paddr_q;
  assign bus.resp_fault = resp_fault_q;
  assign accept = bus.req_valid && bus.req_ready;
  assign ack = state_q == WALK && bus.walk_ack;
  assign inval_walk = bus.inval_valid && bus.inval_vpn == walk_vpn_q;
  // a flush or matching invalidate racing the walk suppresses the install but not the reply
  assign install = ack && !bus.walk_fault && !kill_q && !bus.flush && !inval_walk;

  always_comb begin
    match = '0;
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid_q[i] && tag_q[i] == req_vpn;
      hit_ppn = hit_ppn | (match[i] ? ppn_q[i] : '0);
    end
    hit = |match;
  end

  always_comb begin
    state_d = state_q == IDLE ? ((accept && !hit) ? WALK : IDLE) : (bus.walk_ack ? IDLE : WALK);
  end

  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    ppn_d = ppn_q;
    for (int i = 0; i < ENTRIES; i++)
      if (bus.flush || (bus.inval_valid && tag_q[i] == bus.inval_vpn)) valid_d[i] = 1'b0;
    if (install) begin
      valid_d[victim] = 1'b1;
      tag_d[victim] = walk_vpn_q;
      ppn_d[victim] = bus.walk_ppn;
    end
    resp_valid_d = (accept && hit) || ack;
    resp_fault_d = ack && bus.walk_fault;
    resp_paddr_d = (accept && hit) ? {hit_ppn, bus.req_vaddr[OFS-1:0]} :
                   ack ? (bus.walk_fault ? '0 : {bus.walk_ppn, ofs_q}) : resp_paddr_q;
    walk_vpn_d = (accept && !hit) ? req_vpn : walk_vpn_q;
    ofs_d = (accept && !hit) ? bus.req_vaddr[OFS-1:0] : ofs_q;
    kill_d = (accept && !hit) ? 1'b0 : (state_q == WALK && (bus.flush || inval_walk)) ? 1'b1 : kill_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      walk_vpn_q <= '0;
      ofs_q <= '0;
      kill_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_paddr_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      walk_vpn_q <= walk_vpn_d;
      ofs_q <= ofs_d;
      kill_q <= kill_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_paddr_q <= resp_paddr_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    ppn_q <= ppn_d;
  end

`ifdef TLB_PERF_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  assign hit_count = hit_count_q;
  assign miss_count = miss_count_q;
  always_comb begin
    hit_count_d = (accept && hit) ? hit_count_q + 32'd1 : hit_count_q;
    miss_count_d = (accept && !hit) ? miss_count_q + 32'd1 : miss_count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count_q <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end
`endif
endmodule

// File: tb/tb_tlb_cache.sv
// tb_tlb_cache: scoreboard bench for tlb_cache with ENTRIES=4, 32-bit addresses, 4 KiB pages
module tb_tlb_cache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  int hits_exp = 0;
  int miss_exp = 0;
  typedef struct {
    logic [31:0] pa;
    logic f;
  } exp_t;
  exp_t sb[$];

  tlb_cache_if #(.VADDR_WIDTH(32), .PADDR_WIDTH(32), .PAGE_SIZE(4096)) bus ();
`ifdef TLB_PERF_EN
  logic [31:0] hit_count, miss_count;
  tlb_cache #(.ENTRIES(4), .VADDR_WIDTH(32), .PADDR_WIDTH(32), .PAGE_SIZE(4096)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );
`else
  tlb_cache #(.ENTRIES(4), .VADDR_WIDTH(32), .PADDR_WIDTH(32), .PAGE_SIZE(4096)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected got pa=%h f=%b exp=none", bus.resp_paddr, bus.resp_fault);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.resp_paddr !== e.pa || bus.resp_fault !== e.f) begin
          bad++;
          $display("FAIL resp got pa=%h f=%b exp pa=%h f=%b", bus.resp_paddr, bus.resp_fault, e.pa, e.f);
        end
      end
    end
  end

  task automatic expect_resp(input logic [19:0] ppn, input logic [11:0] ofs, input logic flt);
    exp_t e;
    e.pa = flt ? 32'h0 : {ppn, ofs};
    e.f = flt;
    sb.push_back(e);
  endtask

  task automatic do_req(input logic [19:0] vpn, input logic [11:0] ofs, input logic hit,
                        input logic [19:0] ppn, input logic flt, input logic fl);
    int n = 0;
    expect_resp(ppn, ofs, flt);
    if (hit) hits_exp++;
    else miss_exp++;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_vaddr = {vpn, ofs};
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    if (hit) begin
      chk("hit_lat", {31'b0, bus.resp_valid}, 32'd1);
      chk("hit_nowalk", {31'b0, bus.walk_req}, 32'd0);
    end else begin
      chk("walk_req", {31'b0, bus.walk_req}, 32'd1);
      chk("walk_vpn", {12'b0, bus.walk_vpn}, {12'b0, vpn});
      chk("miss_noresp", {31'b0, bus.resp_valid}, 32'd0);
      bus.flush = fl;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      chk("walk_hold", {31'b0, bus.walk_req}, 32'd1);
      chk("walk_vpn_stable", {12'b0, bus.walk_vpn}, {12'b0, vpn});
      bus.walk_ack = 1'b1;
      bus.walk_ppn = ppn;
      bus.walk_fault = flt;
      @(posedge clk);
      #1 bus.walk_ack = 1'b0;
      bus.walk_fault = 1'b0;
      @(negedge clk);
      chk("walk_drop", {31'b0, bus.walk_req}, 32'd0);
    end
  endtask

  initial begin
    logic [19:0] b2b_vpn [3];
    logic [19:0] b2b_ppn [3];
    int n;
`ifdef TLB_PERF_EN
    logic [31:0] h0, m0;
`endif
    b2b_vpn = '{20'h9, 20'h5, 20'h1};
    b2b_ppn = '{20'h99, 20'h55, 20'h21};
    bus.req_valid = 1'b0;
    bus.req_vaddr = '0;
    bus.walk_ack = 1'b0;
    bus.walk_ppn = '0;
    bus.walk_fault = 1'b0;
    bus.flush = 1'b0;
    bus.inval_valid = 1'b0;
    bus.inval_vpn = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_fault", {31'b0, bus.resp_fault}, 32'd0);
    chk("rst_resp_paddr", bus.resp_paddr, 32'd0);
    chk("rst_walk_req", {31'b0, bus.walk_req}, 32'd0);
    chk("rst_walk_vpn", {12'b0, bus.walk_vpn}, 32'd0);
`ifdef TLB_PERF_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    do_req(20'hFFFFF, 12'h00A, 1'b0, 20'h00100, 1'b0, 1'b0);
    do_req(20'hFFFFF, 12'h00B, 1'b1, 20'h00100, 1'b0, 1'b0);
    @(negedge clk);
    bus.flush = 1'b1;
    #1 chk("flush_blocks", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    for (int v = 1; v <= 4; v++) do_req(20'(v), 12'h004, 1'b0, 20'(v + 'h10), 1'b0, 1'b0);
    do_req(20'h5, 12'h008, 1'b0, 20'h15, 1'b0, 1'b0);
    do_req(20'h2, 12'h00C, 1'b1, 20'h12, 1'b0, 1'b0);
    do_req(20'h1, 12'h010, 1'b0, 20'h21, 1'b0, 1'b0);
    do_req(20'h1, 12'h014, 1'b1, 20'h21, 1'b0, 1'b0);
    do_req(20'h3, 12'h018, 1'b1, 20'h13, 1'b0, 1'b0);
    do_req(20'h5, 12'h01C, 1'b1, 20'h15, 1'b0, 1'b0);
    do_req(20'h2, 12'h020, 1'b0, 20'h22, 1'b0, 1'b0);
    do_req(20'h7, 12'h024, 1'b0, 20'h70, 1'b1, 1'b0);
    do_req(20'h7, 12'h028, 1'b0, 20'h77, 1'b0, 1'b0);
    do_req(20'h7, 12'h02C, 1'b1, 20'h77, 1'b0, 1'b0);
    do_req(20'h9, 12'h030, 1'b0, 20'h99, 1'b0, 1'b1);
    do_req(20'h9, 12'h034, 1'b0, 20'h99, 1'b0, 1'b0);
    do_req(20'h5, 12'h038, 1'b0, 20'h55, 1'b0, 1'b0);
    do_req(20'h1, 12'h03C, 1'b0, 20'h21, 1'b0, 1'b0);
`ifdef TLB_PERF_EN
    h0 = hit_count;
    m0 = miss_count;
`endif
    for (int k = 0; k < 3; k++) begin
      expect_resp(b2b_ppn[k], 12'h040, 1'b0);
      hits_exp++;
    end
    @(negedge clk);
    bus.req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req_vaddr = {b2b_vpn[k], 12'h040};
      @(posedge clk);
      @(negedge clk);
      chk("b2b_resp", {31'b0, bus.resp_valid}, 32'd1);
    end
    bus.req_valid = 1'b0;
`ifdef TLB_PERF_EN
    chk("b2b_hit_delta", hit_count - h0, 32'd3);
    chk("b2b_miss_delta", miss_count - m0, 32'd0);
`endif
    bus.inval_valid = 1'b1;
    bus.inval_vpn = 20'h5;
    @(posedge clk);
    #1 bus.inval_valid = 1'b0;
    do_req(20'h5, 12'h044, 1'b0, 20'h56, 1'b0, 1'b0);
    do_req(20'h5, 12'h048, 1'b1, 20'h56, 1'b0, 1'b0);
    do_req(20'h9, 12'h04C, 1'b1, 20'h99, 1'b0, 1'b0);
    bus.walk_ack = 1'b1;
    bus.walk_ppn = 20'h3;
    @(posedge clk);
    #1 bus.walk_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_noresp", {31'b0, bus.resp_valid}, 32'd0);
    chk("idle_ack_nowalk", {31'b0, bus.walk_req}, 32'd0);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
`ifdef TLB_PERF_EN
    chk("hit_count", hit_count, 32'(hits_exp));
    chk("miss_count", miss_count, 32'(miss_exp));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
